// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-through, no-write-allocate data cache; define DCACHE_STATS_EN for hit/miss counters
module dcache_direct #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int SETS           = 64,
  parameter int IDX_W          = $clog2(SETS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_LENGTH-1:0] a,
  input  logic [ADDRESS_LENGTH-1:0] wd,
  input  logic                      re,
  input  logic                      sw,
  input  logic                      sh,
  input  logic                      sb,
  output logic [ADDRESS_LENGTH-1:0] rd,
  output logic                      stall,
  output logic [ADDRESS_LENGTH-1:0] mem_a,
  output logic [ADDRESS_LENGTH-1:0] mem_wd,
  output logic                      mem_sw,
  output logic                      mem_sh,
  output logic                      mem_sb,
`ifdef DCACHE_STATS_EN
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count,
`endif
  input  logic [ADDRESS_LENGTH-1:0] mem_rd
);
  localparam int TAG_W = ADDRESS_LENGTH - IDX_W - 2;
  localparam int NB    = ADDRESS_LENGTH / 8;
  typedef enum logic {IDLE, FILL} state_t;
  state_t                       r_state, w_next;
  logic [SETS-1:0]              r_valid;
  logic [TAG_W-1:0]             r_tag [SETS];
  logic [ADDRESS_LENGTH-1:0]    r_data [SETS];
  logic [ADDRESS_LENGTH-3:0]    r_wa;
  logic [1:0]                   w_off;
  logic [IDX_W-1:0]             w_idx, w_fidx;
  logic [TAG_W-1:0]             w_tag, w_ftag;
  logic                         w_idle, w_store, w_match, w_miss, w_cross;
  logic [NB-1:0]                w_be;
  logic [ADDRESS_LENGTH-1:0]    w_wdat;
  assign w_off   = a[1:0];
  assign w_idx   = a[IDX_W+1:2];
  assign w_tag   = a[ADDRESS_LENGTH-1:IDX_W+2];
  assign w_fidx  = r_wa[IDX_W-1:0];
  assign w_ftag  = r_wa[ADDRESS_LENGTH-3:IDX_W];
  assign w_idle  = r_state == IDLE;
  assign w_store = w_idle && (sw || sh || sb);
  assign w_match = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_miss  = w_idle && !rst && re && !(sw || sh || sb) && !w_match;
  assign w_cross = (sh && w_off == 2'd3) || (sw && w_off != 2'd0);
  assign w_be    = sb ? NB'(1) << w_off : sh ? NB'(3) << w_off : '1;
  assign w_wdat  = wd << {w_off, 3'b000};
  assign rd      = r_data[w_idx] >> {w_off, 3'b000};
  // next state and RAM-side outputs; everything quiet while reset is held
  always_comb begin
    w_next = w_idle ? (w_miss ? FILL : IDLE) : IDLE;
    stall  = !rst && (!w_idle || w_miss);
    mem_a  = w_idle ? a : {r_wa, 2'b00};
    mem_wd = wd;
    mem_sw = !rst && w_idle && sw;
    mem_sh = !rst && w_idle && sh;
    mem_sb = !rst && w_idle && sb;
  end
  // state, latched fill address and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wa    <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_wa <= a[ADDRESS_LENGTH-1:2];
      if (!w_idle) r_valid[w_fidx] <= 1'b1;
      else if (w_store && w_cross) r_valid[w_idx] <= 1'b0;
    end
  end
  // tag and data arrays carry no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_idle) begin
        r_tag[w_fidx]  <= w_ftag;
        r_data[w_fidx] <= mem_rd;
      end else if (w_store && !w_cross && w_match) begin
        for (int i = 0; i < NB; i++)
          if (w_be[i]) r_data[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end
`ifdef DCACHE_STATS_EN
  logic r_replay;
  logic w_hit;
  assign w_hit = w_idle && re && !(sw || sh || sb) && w_match && !r_replay;
  // saturating hit/miss counters; the replay after a fill is not a hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_replay   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      r_replay <= !w_idle;
      if (w_hit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (w_miss && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule
